// File: rtl/farrow_resample_ctrl.sv
// Farrow resampler sequencer: Q2.14 phase accumulator feeds the interpolator and discards skip outputs.
// Latency accept->out_valid = LATENCY+2; in_ready only in RUN, no downstream backpressure.
module farrow_resample_ctrl #(
    parameter int LATENCY = 7,
    parameter int W       = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] step_in,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         f_enable,
    output logic [W-1:0] f_mu,
    output logic [W-1:0] f_data,
    input  logic         f_enable_out,
    input  logic [W-1:0] f_data_out,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         done,
    output logic         step_err
);

    localparam int FB = W - 2;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY);
    localparam logic [W-2:0]  STEP_MIN = {1'b1, {FB{1'b0}}};
    localparam logic [W-2:0]  STEP_MAX = {(W-1){1'b1}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-2:0]  step_q, step_d;
    logic [FB-1:0] acc_q, acc_d;
    logic          skip_q, skip_d;
    logic          keep_q, keep_d;
    logic          f_enable_q, f_enable_d;
    logic [W-1:0]  f_mu_q, f_mu_d;
    logic [W-1:0]  f_data_q, f_data_d;
    logic [LATENCY-1:0] kdl_q;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic          done_q, done_d;
    logic          step_err_q, step_err_d;
    logic [W-1:0]  nxt;
    logic          accept;

    assign in_ready = (state_q == S_RUN);
    assign busy     = (state_q != S_IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        acc_d      = acc_q;
        skip_d     = skip_q;
        keep_d     = 1'b0;
        f_enable_d = 1'b0;
        f_mu_d     = f_mu_q;
        f_data_d   = f_data_q;
        done_d     = 1'b0;
        step_err_d = step_err_q;
        // acc < 1.0 and step < 2.0, so the sum never exceeds W bits
        nxt        = W'(acc_q) + W'(step_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    skip_d  = 1'b0;
                    if (step_in[W-1]) begin
                        step_d     = STEP_MAX;
                        step_err_d = 1'b1;
                    end else if (step_in[W-2:0] < STEP_MIN) begin
                        step_d     = STEP_MIN;
                        step_err_d = 1'b1;
                    end else begin
                        step_d = step_in[W-2:0];
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            f_enable_d = 1'b1;
            f_data_d   = in_data;
            if (!skip_q) begin
                keep_d = 1'b1;
                f_mu_d = {2'b00, acc_q};
                // integer part of nxt is 1 or 2; 2 means the next input is stepped over
                skip_d = (nxt[W-1:FB] == 2'd2);
                acc_d  = nxt[FB-1:0];
            end else begin
                skip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            skip_q      <= 1'b0;
            keep_q      <= 1'b0;
            f_enable_q  <= 1'b0;
            f_mu_q      <= '0;
            f_data_q    <= '0;
            kdl_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            skip_q     <= skip_d;
            keep_q     <= keep_d;
            f_enable_q <= f_enable_d;
            f_mu_q     <= f_mu_d;
            f_data_q   <= f_data_d;
            done_q     <= done_d;
            step_err_q <= step_err_d;
            kdl_q[0]   <= keep_q & f_enable_q;
            for (int i = 1; i < LATENCY; i++) begin
                kdl_q[i] <= kdl_q[i-1];
            end
            out_valid_q <= f_enable_out & kdl_q[LATENCY-1];
            if (f_enable_out && kdl_q[LATENCY-1]) begin
                out_data_q <= f_data_out;
            end
        end
    end

    assign f_enable  = f_enable_q;
    assign f_mu      = f_mu_q;
    assign f_data    = f_data_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign step_err  = step_err_q;

endmodule

// File: tb/tb_farrow_resample_ctrl.sv
// Bench for farrow_resample_ctrl with a fixed-latency interpolator stand-in and a phase-position model.
module tb_farrow_resample_ctrl;

    localparam int L = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [15:0] step_in = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, f_enable, out_valid, busy, done, step_err;
    logic [15:0] f_mu, f_data, out_data;
    logic        f_enable_out;
    logic [15:0] f_data_out;

    farrow_resample_ctrl #(.LATENCY(L), .W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step_in(step_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .f_enable(f_enable), .f_mu(f_mu), .f_data(f_data),
        .f_enable_out(f_enable_out), .f_data_out(f_data_out),
        .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done), .step_err(step_err)
    );

    always #5 clk = ~clk;

    // Interpolator stand-in: fixed L-cycle pipe, output = data ^ mu so mu errors show in out_data.
    logic [L-1:0] en_pipe = '0;
    logic [15:0]  dat_pipe [L];
    always @(posedge clk) begin
        en_pipe     <= {en_pipe[L-2:0], f_enable};
        dat_pipe[0] <= f_data ^ f_mu;
        for (int i = 1; i < L; i++) dat_pipe[i] <= dat_pipe[i-1];
    end
    assign f_enable_out = en_pipe[L-1];
    assign f_data_out   = dat_pipe[L-1];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model: output j sits at position j*step (Q14); it is taken from input floor(pos) with mu = frac(pos).
    typedef struct { int cyc; logic [15:0] dat; } exp_t;
    exp_t        exp_q[$];
    longint      m_step, m_j;
    longint      m_k;
    bit          mon_en = 1'b0;
    int          out_cnt = 0;
    bit          pend_vld = 1'b0, pend_keep = 1'b0;
    logic [15:0] pend_mu, pend_dat;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (pend_vld) begin
                chk("f_enable", f_enable, 1);
                chk("f_data", f_data, pend_dat);
                if (pend_keep) chk("f_mu", f_mu, pend_mu);
            end else if (f_enable) begin
                chk("f_enable_spurious", f_enable, 0);
            end
            pend_vld = 1'b0;
            if (in_valid && in_ready) begin
                pend_vld  = 1'b1;
                pend_dat  = in_data;
                pend_keep = 1'b0;
                if (((m_j * m_step) >> 14) == m_k) begin
                    pend_keep = 1'b1;
                    pend_mu   = 16'((m_j * m_step) & 64'd16383);
                    exp_q.push_back('{cyc: cyc + L + 2, dat: in_data ^ pend_mu});
                    m_j++;
                end
                m_k++;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("out_missing", 0, 1);
                void'(exp_q.pop_front());
            end
            if (out_valid) begin
                out_cnt++;
                if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    chk("out_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                    chk("out_data", out_data, exp_q[0].dat);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    function automatic longint clamp(input logic [15:0] s);
        if (s < 16'd16384) return 16384;
        if (s >= 16'd32768) return 32767;
        return longint'(s);
    endfunction

    function automatic int model_count(input longint s, input int n);
        int c = 0;
        for (longint j = 0; ((j * s) >> 14) < n; j++) c++;
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] s);
        m_step  = clamp(s);
        m_j     = 0;
        m_k     = 0;
        out_cnt = 0;
        step_in = s;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic feed(input int n, input int gap);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 1000) begin
            in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            tick();
            if (in_valid) sent++;
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_run;
        int w = 0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        while (!done && w < 50) begin
            tick();
            w++;
        end
        chk("done_seen", done, 1);
        tick();
        tick();
        chk("queue_drained", 64'(exp_q.size()), 0);
    endtask

    typedef struct {
        logic [15:0] step;
        int          n;
        int          gap;
        int          exp_outs;
        bit          exp_err;
    } vec_t;
    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'd16384, 20, 0, 20, 1'b0};
        tbl[1] = '{16'd24576, 12, 0,  8, 1'b0};
        tbl[2] = '{16'd20480, 10, 0,  8, 1'b0};
        tbl[3] = '{16'd24576, 12, 1,  8, 1'b0};
        tbl[4] = '{16'd32767, 10, 0,  6, 1'b0};
        tbl[5] = '{16'd20480, 10, 2,  8, 1'b0};
        tbl[6] = '{16'd40000, 10, 0,  6, 1'b1};
        tbl[7] = '{16'd100,   10, 0, 10, 1'b1};
        tbl[8] = '{16'd16383, 10, 0, 10, 1'b1};
        tbl[9] = '{16'd32768, 10, 0,  6, 1'b1};

        // reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_f_enable", f_enable, 0);
        chk("rst_f_mu", f_mu, 0);
        chk("rst_f_data", f_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step_err", step_err, 0);
        rst = 1'b1;
        tick();
        mon_en = 1'b1;

        foreach (tbl[i]) begin
            start_run(tbl[i].step);
            chk("step_err", step_err, tbl[i].exp_err);
            feed(tbl[i].n, tbl[i].gap);
            finish_run();
            chk("out_count", 64'(out_cnt), 64'(tbl[i].exp_outs));
            tick();
        end

        // stop timing: in_ready drops next cycle, busy for L+1 cycles, single done pulse
        start_run(16'd20480);
        feed(3, 0);
        stop = 1'b1;
        chk("stop_cycle_ready", in_ready, 1);
        tick();
        stop = 1'b0;
        chk("drain_in_ready", in_ready, 0);
        chk("drain_busy", busy, 1);
        for (int i = 0; i < L; i++) begin
            tick();
            chk("drain_busy_hold", busy, 1);
            chk("drain_no_done", done, 0);
        end
        tick();
        chk("drain_end_busy", busy, 0);
        chk("drain_done", done, 1);
        tick();
        chk("done_one_shot", done, 0);
        tick();
        chk("stop_run_out_count", 64'(out_cnt), 3);

        // start and stop together in IDLE: start wins
        m_step = 16384; m_j = 0; m_k = 0; out_cnt = 0;
        step_in = 16'd16384;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_wins_ready", in_ready, 1);
        feed(4, 0);
        finish_run();
        chk("start_wins_outs", 64'(out_cnt), 4);

        // reset mid-run: outputs clear immediately, nothing stale afterwards
        start_run(16'd24576);
        feed(6, 0);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        mon_en   = 1'b0;
        rst      = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_f_enable", f_enable, 0);
        chk("mid_rst_f_mu", f_mu, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_step_err", step_err, 0);
        in_valid = 1'b0;
        exp_q.delete();
        pend_vld = 1'b0;
        tick();
        tick();
        rst     = 1'b1;
        out_cnt = 0;
        mon_en  = 1'b1;
        repeat (L + 6) tick();
        chk("no_stale_out", 64'(out_cnt), 0);

        // randomized legal ratios with random gaps
        for (int r = 0; r < 6; r++) begin
            logic [15:0] s;
            int n;
            s = 16'($urandom_range(16384, 32767));
            n = $urandom_range(5, 30);
            start_run(s);
            chk("rand_step_err", step_err, 0);
            feed(n, 2);
            finish_run();
            chk("rand_out_count", 64'(out_cnt), 64'(model_count(clamp(s), n)));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
